// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: bundles the branch-select, instruction-memory and decode
// handshake signals of the ZAFx32 fetch unit.
// master = the fetch unit itself, slave = its surroundings (memory/branch/decode).
interface pc_fetch_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          instr_valid;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] instr_pc;
  logic          dec_ready;

  modport master (
    input  branch_taken, branch_target, imem_ack, imem_rdata, dec_ready,
    output imem_req, imem_addr, instr_valid, instr_out, instr_pc
  );

  modport slave (
    output branch_taken, branch_target, imem_ack, imem_rdata, dec_ready,
    input  imem_req, imem_addr, instr_valid, instr_out, instr_pc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the ZAFx32 program counter, fetches one instruction at a
// time over a req/ack memory handshake and buffers it for decode (valid/ready).
// A branch redirect never lets a pre-branch instruction reach decode.
// Optional build macro FETCH_PERF_EN adds saturating fetch/flush counters.
module pc_fetch_unit #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst,
  pc_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_DISCARD = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] redir_q;
  logic          req_q;
  logic          valid_q;
  logic [DW-1:0] instr_q;
  logic [AW-1:0] ipc_q;

  // A memory completion only means something while our request is raised.
  logic fetch_ack;
  assign fetch_ack = req_q & bus.imem_ack;

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_pc    = ipc_q;

  // Fetch FSM: request, optionally throw away a pending fetch after a redirect, then hold for decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      redir_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          if (!req_q) begin
            // First cycle after reset: nothing is outstanding, so a redirect just moves the pc.
            req_q <= 1'b1;
            if (bus.branch_taken) begin
              pc_q <= bus.branch_target;
            end
          end else if (fetch_ack) begin
            if (bus.branch_taken) begin
              // Returned data is from the wrong path; re-request at the target next cycle.
              pc_q <= bus.branch_target;
            end else begin
              instr_q <= bus.imem_rdata;
              ipc_q   <= pc_q;
              pc_q    <= pc_q + 1'b1;
              valid_q <= 1'b1;
              req_q   <= 1'b0;
              state_q <= S_HOLD;
            end
          end else if (bus.branch_taken) begin
            // The address must stay stable until the ack, so remember where to go afterwards.
            redir_q <= bus.branch_target;
            state_q <= S_DISCARD;
          end
        end

        S_DISCARD: begin
          if (fetch_ack) begin
            pc_q    <= bus.branch_taken ? bus.branch_target : redir_q;
            state_q <= S_REQ;
          end else if (bus.branch_taken) begin
            redir_q <= bus.branch_target;
          end
        end

        S_HOLD: begin
          if (bus.branch_taken) begin
            valid_q <= 1'b0;
            pc_q    <= bus.branch_target;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end else if (bus.dec_ready) begin
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end

        default: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_evt;
  logic flush_evt;

  // Classify this cycle: a completed fetch, and/or an instruction lost to a redirect.
  always_comb begin
    fetch_evt = fetch_ack && ((state_q == S_REQ) || (state_q == S_DISCARD));
    flush_evt = 1'b0;
    if (fetch_ack && (state_q == S_DISCARD)) begin
      flush_evt = 1'b1;
    end
    if (fetch_ack && (state_q == S_REQ) && bus.branch_taken) begin
      flush_evt = 1'b1;
    end
    if ((state_q == S_HOLD) && bus.branch_taken && !bus.dec_ready) begin
      flush_evt = 1'b1;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (fetch_evt && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (flush_evt && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit. A memory model answers
// requests with a fixed latency; kept fetches are queued and compared when decode
// takes them, redirected/flushed ones are dropped from the model.
module tb_pc_fetch_unit;
  localparam int            AW     = 32;
  localparam int            DW     = 32;
  localparam logic [AW-1:0] RST_PC = '0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // 10 ns clock
  always #5 clk = ~clk;

  pc_fetch_unit_if #(.AW(AW), .DW(DW)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  pc_fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] mpc;
  logic [AW-1:0] redir;
  logic          discarding;
  int            lat;
  int            cnt;
  int            n_fetch;
  int            n_flush;
  logic          held;
  logic [DW-1:0] held_out;
  logic [AW-1:0] held_pc;

  function automatic logic [DW-1:0] memData(input logic [AW-1:0] a);
    return ~a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    sb.delete();
    mpc        = RST_PC;
    redir      = '0;
    discarding = 1'b0;
    cnt        = 0;
    n_fetch    = 0;
    n_flush    = 0;
    held       = 1'b0;
  endtask

  task automatic doReset();
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.dec_ready     = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_req",   bus.imem_req,    0);
    checkOutput("rst_valid", bus.instr_valid, 0);
    checkOutput("rst_out",   bus.instr_out,   0);
    checkOutput("rst_ipc",   bus.instr_pc,    0);
    checkOutput("rst_addr",  bus.imem_addr,   RST_PC);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("req_after_release", bus.imem_req, 0);
  endtask

  // One cycle: observe outputs at the negedge, drive inputs, update the model.
  task automatic applyStimulus(input logic br_en, input logic [AW-1:0] tgt,
                               input logic rdy, input logic only_req);
    logic br;
    logic ack;
    exp_t e;
    @(negedge clk);
    br  = br_en && (!only_req || bus.imem_req);
    ack = 1'b0;
    if (bus.imem_req) begin
      checkOutput("imem_addr", bus.imem_addr, mpc);
      if (cnt >= lat) begin
        ack = 1'b1;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.dec_ready     = rdy;
    bus.imem_ack      = ack;
    bus.imem_rdata    = ack ? memData(bus.imem_addr) : '0;

    if (bus.instr_valid) begin
      checkOutput("req_in_hold", bus.imem_req, 0);
      if (rdy) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("instr_pc",  bus.instr_pc,  e.pc);
          checkOutput("instr_out", bus.instr_out, e.instr);
        end
        held = 1'b0;
      end else if (held) begin
        checkOutput("hold_out", bus.instr_out, held_out);
        checkOutput("hold_pc",  bus.instr_pc,  held_pc);
      end else begin
        held     = 1'b1;
        held_out = bus.instr_out;
        held_pc  = bus.instr_pc;
      end
      if (br) begin
        mpc = tgt;
        if (!rdy) begin
          if (sb.size() > 0) void'(sb.pop_front());
          n_flush++;
        end
        held = 1'b0;
      end
    end

    if (bus.imem_req && ack) begin
      n_fetch++;
      if (discarding) begin
        mpc        = br ? tgt : redir;
        discarding = 1'b0;
        n_flush++;
      end else if (br) begin
        mpc = tgt;
        n_flush++;
      end else begin
        e.pc    = mpc;
        e.instr = memData(mpc);
        sb.push_back(e);
        mpc = mpc + 1'b1;
      end
    end else if (bus.imem_req && br) begin
      discarding = 1'b1;
      redir      = tgt;
    end
  endtask

  task automatic waitValid();
    int n = 0;
    while (!bus.instr_valid && n < 20) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      n++;
    end
    if (n >= 20) checkOutput("wait_valid_timeout", 0, 1);
  endtask

  // Hard stop in case something wedges the sequence below.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence; all checking is done inside applyStimulus and doReset.
  initial begin
    lat = 0;
    modelReset();
    doReset();

    // zero-wait streaming from RESET_PC
    repeat (12) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // decode stalls: instruction must be held stable with no request
    repeat (7) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // redirect while an instruction is held
    waitValid();
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // redirect while a slow request to 0x10 is pending
    lat = 3;
    waitValid();
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h80, 1'b1, 1'b0);
    repeat (14) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // redirect coinciding with the memory ack
    lat = 0;
    repeat (2) applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // pc wrap-around
    waitValid();
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b0);

`ifdef FETCH_PERF_EN
    @(posedge clk);
    #1;
    checkOutput("perf_fetch", perf_fetch_cnt, n_fetch);
    checkOutput("perf_flush", perf_flush_cnt, n_flush);
`endif
    checkOutput("sb_backlog", (sb.size() > 1), 0);

    // reset in the middle of a long request
    lat = 8;
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("mid_req_pending", bus.imem_req, 1);
    doReset();
    lat = 0;
    repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
